// File: rtl/writeback_arbiter.sv
// -----------------------------------------------------------------------------
// writeback_arbiter
//   Drives the single write port of the 32x32 register file. Single-cycle ALU
//   results and out-of-order load returns share that port. Load returns are
//   always queued in a small FIFO and are never bypassed. Each cycle, one
//   source is selected from the registered FIFO occupancy:
//     - FIFO full          : drain the FIFO head. The ALU is stalled.
//     - ALU valid          : write the ALU result.
//     - FIFO not empty     : drain the FIFO head.
//     - otherwise          : no write.
//   A selected entry with rd==0 is consumed without a write. When no write
//   occurs, rd_o and wd_o keep their last values.
//
// Parameters
//   DEPTH        load-result FIFO depth. Must be a power of two and >= 2.
//
// Ports
//   clk_i        clock, rising edge
//   reset_ni     asynchronous active-low reset
//   alu_valid_i  ALU result valid
//   alu_rd_i     ALU destination register
//   alu_wd_i     ALU result data
//   alu_ready_o  ALU result accepted (low only while the FIFO is full)
//   lsu_valid_i  load result valid
//   lsu_rd_i     load destination register
//   lsu_wd_i     load data
//   lsu_ready_o  FIFO can accept a load result
//   regwrite_o   register file write enable (registered)
//   rd_o         register file write address (registered)
//   wd_o         register file write data (registered)
//   stall_cnt_o  saturating count of cycles in which the ALU was stalled.
//                This port exists only when WB_PERF_EN is defined.
//
// Build option
//   WB_PERF_EN   adds the stall_cnt_o port and its counter.
// -----------------------------------------------------------------------------
module writeback_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        alu_valid_i,
  input  logic [4:0]  alu_rd_i,
  input  logic [31:0] alu_wd_i,
  output logic        alu_ready_o,
  input  logic        lsu_valid_i,
  input  logic [4:0]  lsu_rd_i,
  input  logic [31:0] lsu_wd_i,
  output logic        lsu_ready_o,
  output logic        regwrite_o,
  output logic [4:0]  rd_o,
  output logic [31:0] wd_o
`ifdef WB_PERF_EN
  ,
  output logic [31:0] stall_cnt_o
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [4:0]    rd_mem [DEPTH];
  logic [31:0]   wd_mem [DEPTH];
  logic [CW-1:0] count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  logic          full;
  logic          empty;
  logic          sel_alu;
  logic          pop;
  logic          push;
  logic [4:0]    sel_rd;
  logic [31:0]   sel_wd;

  // Source selection uses only the registered count, so both ready outputs
  // are independent of the valid inputs.
  always_comb begin
    full    = (count == FULL_CNT);
    empty   = (count == '0);
    sel_alu = alu_valid_i && !full;
    pop     = full || (!alu_valid_i && !empty);
    push    = lsu_valid_i && !full;
    sel_rd  = sel_alu ? alu_rd_i : rd_mem[rd_ptr];
    sel_wd  = sel_alu ? alu_wd_i : wd_mem[rd_ptr];
  end

  assign alu_ready_o = !full;
  assign lsu_ready_o = !full;

  // The data array has no reset. Reset discards entries by clearing the
  // count and the pointers.
  always_ff @(posedge clk_i) begin
    if (push) begin
      rd_mem[wr_ptr] <= lsu_rd_i;
      wd_mem[wr_ptr] <= lsu_wd_i;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      count <= count + CW'(push) - CW'(pop);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // A write to x0 is consumed here and never reaches the register file.
  // rd_o and wd_o change only when a real write is issued.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      regwrite_o <= 1'b0;
      rd_o       <= '0;
      wd_o       <= '0;
    end else if ((sel_alu || pop) && (sel_rd != '0)) begin
      regwrite_o <= 1'b1;
      rd_o       <= sel_rd;
      wd_o       <= sel_wd;
    end else begin
      regwrite_o <= 1'b0;
    end
  end

`ifdef WB_PERF_EN
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      stall_cnt_o <= '0;
    end else if (alu_valid_i && full && (stall_cnt_o != 32'hFFFF_FFFF)) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;
  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b1;
  logic        alu_valid_i = 1'b0;
  logic [4:0]  alu_rd_i = '0;
  logic [31:0] alu_wd_i = '0;
  logic        alu_ready_o;
  logic        lsu_valid_i = 1'b0;
  logic [4:0]  lsu_rd_i = '0;
  logic [31:0] lsu_wd_i = '0;
  logic        lsu_ready_o;
  logic        regwrite_o;
  logic [4:0]  rd_o;
  logic [31:0] wd_o;
`ifdef WB_PERF_EN
  logic [31:0] stall_cnt_o;
`endif

  writeback_arbiter #(.DEPTH(DEPTH)) dut (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .alu_valid_i (alu_valid_i),
    .alu_rd_i    (alu_rd_i),
    .alu_wd_i    (alu_wd_i),
    .alu_ready_o (alu_ready_o),
    .lsu_valid_i (lsu_valid_i),
    .lsu_rd_i    (lsu_rd_i),
    .lsu_wd_i    (lsu_wd_i),
    .lsu_ready_o (lsu_ready_o),
    .regwrite_o  (regwrite_o),
    .rd_o        (rd_o),
    .wd_o        (wd_o)
`ifdef WB_PERF_EN
    ,
    .stall_cnt_o (stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model. The pending loads are held in a queue. The queue size
  // is the occupancy, and arbitration follows the priority rules directly.
  logic [36:0] q[$];
  logic        exp_rw;
  logic [4:0]  exp_rd;
  logic [31:0] exp_wd;
  logic [31:0] exp_stall;

  always @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      q.delete();
      exp_rw = 1'b0; exp_rd = '0; exp_wd = '0; exp_stall = '0;
    end else begin
      logic        is_full;
      logic        have;
      logic [36:0] ent;
      is_full = (q.size() == DEPTH);
      have    = 1'b0;
      ent     = '0;
      if (alu_valid_i && is_full && exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 1;
      if (alu_valid_i && !is_full) begin
        have = 1'b1; ent = {alu_rd_i, alu_wd_i};
      end else if (q.size() > 0) begin
        have = 1'b1; ent = q.pop_front();
      end
      if (lsu_valid_i && !is_full) q.push_back({lsu_rd_i, lsu_wd_i});
      if (have && ent[36:32] != 5'd0) begin
        exp_rw = 1'b1; exp_rd = ent[36:32]; exp_wd = ent[31:0];
      end else begin
        exp_rw = 1'b0;
      end
    end
  end

  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("cyc_regwrite", 32'(regwrite_o), 32'(exp_rw));
      chk("cyc_rd", 32'(rd_o), 32'(exp_rd));
      chk("cyc_wd", wd_o, exp_wd);
      chk("cyc_alu_ready", 32'(alu_ready_o), 32'(q.size() != DEPTH));
      chk("cyc_lsu_ready", 32'(lsu_ready_o), 32'(q.size() != DEPTH));
`ifdef WB_PERF_EN
      chk("cyc_stall_cnt", stall_cnt_o, exp_stall);
`endif
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_alu(input logic v, input logic [4:0] rd, input logic [31:0] wd);
    alu_valid_i = v; alu_rd_i = rd; alu_wd_i = wd;
  endtask

  task automatic drive_lsu(input logic v, input logic [4:0] rd, input logic [31:0] wd);
    lsu_valid_i = v; lsu_rd_i = rd; lsu_wd_i = wd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int writes;
    // Reset
    #1 reset_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    reset_ni = 1'b1;
    chk_en   = 1'b1;
    #1;
    chk("rst_regwrite", 32'(regwrite_o), 0);
    chk("rst_rd", 32'(rd_o), 0);
    chk("rst_wd", wd_o, 0);
    chk("rst_alu_ready", 32'(alu_ready_o), 1);
    chk("rst_lsu_ready", 32'(lsu_ready_o), 1);

    // Single ALU write
    drive_alu(1, 5, 32'hDEAD_BEEF);
    tick();
    drive_alu(0, 0, 0);
    chk("alu_regwrite", 32'(regwrite_o), 1);
    chk("alu_rd", 32'(rd_o), 5);
    chk("alu_wd", wd_o, 32'hDEAD_BEEF);
    tick();
    chk("alu_idle_regwrite", 32'(regwrite_o), 0);

    // ALU write to x0 is dropped
    drive_alu(1, 0, 32'h1234);
    tick();
    drive_alu(0, 0, 0);
    chk("x0_alu_regwrite", 32'(regwrite_o), 0);
    chk("x0_alu_rd_hold", 32'(rd_o), 5);
    chk("x0_alu_wd_hold", wd_o, 32'hDEAD_BEEF);

    // Load to x0 is consumed without a write
    drive_lsu(1, 0, 32'h55);
    tick();
    drive_lsu(0, 0, 0);
    tick();
    tick();
    chk("x0_lsu_regwrite", 32'(regwrite_o), 0);
    chk("x0_lsu_wd_hold", wd_o, 32'hDEAD_BEEF);

    // Loads under continuous ALU pressure
    for (int i = 0; i < 4; i++) begin
      drive_alu(1, 5'(20 + i), 32'(i));
      drive_lsu(1, 5'(10 + i), 32'(100 + i));
      tick();
      chk("press_alu_rd", 32'(rd_o), 32'(20 + i));
    end
    drive_alu(1, 24, 32'd4);
    drive_lsu(0, 0, 0);
    chk("press_full_lsu_ready", 32'(lsu_ready_o), 0);
    chk("press_full_alu_ready", 32'(alu_ready_o), 0);
    tick();
    chk("press_stall_regwrite", 32'(regwrite_o), 1);
    chk("press_stall_rd", 32'(rd_o), 10);
    chk("press_stall_wd", wd_o, 100);
    chk("press_after_alu_ready", 32'(alu_ready_o), 1);
`ifdef WB_PERF_EN
    chk("press_stall_cnt", stall_cnt_o, 1);
`endif
    tick();
    chk("press_held_alu_rd", 32'(rd_o), 24);
    drive_alu(0, 0, 0);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("press_drain_rd", 32'(rd_o), 32'(10 + i));
      chk("press_drain_wd", wd_o, 32'(100 + i));
    end
    tick();
    chk("press_done_regwrite", 32'(regwrite_o), 0);

    // Back-to-back loads across the pointer wrap
    for (int i = 1; i <= 6; i++) begin
      drive_lsu(1, 5'(i), 32'(200 + i));
      tick();
      if (i == 1) begin
        chk("wrap_first_latency", 32'(regwrite_o), 0);
      end else begin
        chk("wrap_regwrite", 32'(regwrite_o), 1);
        chk("wrap_rd", 32'(rd_o), 32'(i - 1));
      end
    end
    drive_lsu(0, 0, 0);
    tick();
    chk("wrap_last_rd", 32'(rd_o), 6);
    chk("wrap_last_wd", wd_o, 206);
    tick();
    chk("wrap_idle", 32'(regwrite_o), 0);

    // Reset while loads are pending
    for (int i = 0; i < 3; i++) begin
      drive_alu(1, 7, 32'd77);
      drive_lsu(1, 5'(14 + i), 32'(300 + i));
      tick();
    end
    drive_alu(0, 0, 0);
    drive_lsu(0, 0, 0);
    chk("mid_pre_regwrite", 32'(regwrite_o), 1);
    reset_ni = 1'b0;
    #1;
    chk("mid_async_regwrite", 32'(regwrite_o), 0);
    chk("mid_async_rd", 32'(rd_o), 0);
    chk("mid_async_wd", wd_o, 0);
    @(posedge clk_i);
    @(negedge clk_i);
    reset_ni = 1'b1;
    writes = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (regwrite_o === 1'b1) writes++;
    end
    chk("mid_no_stale_writes", 32'(writes), 0);
`ifdef WB_PERF_EN
    chk("mid_stall_cnt_reset", stall_cnt_o, 0);
`endif

    @(negedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
